// File: rtl/obi_mem_responder.sv
// OBI data-memory responder: byte-masked word writes, full-word reads, and in-order
// responses through a fixed-latency delay line, with grants capped by outstanding count.
module obi_mem_responder #(
    parameter int DEPTH           = 256,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 data_req_i,
    output logic                                 data_gnt_o,
    input  logic [31:0]                          data_addr_i,
    input  logic                                 data_we_i,
    input  logic [3:0]                           data_be_i,
    input  logic [31:0]                          data_wdata_i,
    output logic                                 data_rvalid_o,
    output logic [31:0]                          data_rdata_o,
    input  logic                                 gnt_stall_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic          accept;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q [LATENCY];
    logic [31:0]   rdata_q [LATENCY];
    logic          vld_d;
    logic [31:0]   rdata_d;
    logic          unused_addr_bits;

    // Address wraps modulo DEPTH words; sub-word and upper bits are don't-care.
    assign idx              = data_addr_i[AW+1:2];
    assign unused_addr_bits = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};

    // The cap compares against the registered count, so a slot freed by this
    // cycle's rvalid only becomes usable next cycle.
    assign data_gnt_o    = data_req_i & ~gnt_stall_i & ~rst_i & (cnt_q < CW'(MAX_OUTSTANDING));
    assign accept        = data_req_i & data_gnt_o;
    assign data_rvalid_o = vld_q[LATENCY-1] & ~rst_i;
    assign data_rdata_o  = data_rvalid_o ? rdata_q[LATENCY-1] : 32'h0;
    assign outstanding_o = rst_i ? '0 : cnt_q;

    always_comb begin
        vld_d   = accept;
        rdata_d = 32'h0;
        if (accept && !data_we_i) begin
            rdata_d = mem_q[idx];
        end

        cnt_d = cnt_q;
        case ({accept, data_rvalid_o})
            2'b10: cnt_d = cnt_q + CW'(1);
            2'b01: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state: valid bits and outstanding count are the only reset targets.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
            end
        end else begin
            cnt_q    <= cnt_d;
            vld_q[0] <= vld_d;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q[0] <= rdata_d;
        for (int i = 1; i < LATENCY; i++) begin
            rdata_q[i] <= rdata_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder: three instances cover LATENCY=1, a deep
// pipeline with a wide cap, and a deep pipeline with a tight cap.
module tb_obi_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        stall [3];
    logic        gnt   [3];
    logic        rvld  [3];
    logic [31:0] rdata [3];
    logic [1:0]  out_a;
    logic [2:0]  out_b;
    logic [1:0]  out_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obi_mem_responder #(.DEPTH(256), .LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]),
        .data_wdata_i(wdata[0]), .data_rvalid_o(rvld[0]), .data_rdata_o(rdata[0]),
        .gnt_stall_i(stall[0]), .outstanding_o(out_a));

    obi_mem_responder #(.DEPTH(256), .LATENCY(3), .MAX_OUTSTANDING(4)) u_b (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]),
        .data_wdata_i(wdata[1]), .data_rvalid_o(rvld[1]), .data_rdata_o(rdata[1]),
        .gnt_stall_i(stall[1]), .outstanding_o(out_b));

    obi_mem_responder #(.DEPTH(256), .LATENCY(3), .MAX_OUTSTANDING(2)) u_c (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_addr_i(addr[2]), .data_we_i(we[2]), .data_be_i(be[2]),
        .data_wdata_i(wdata[2]), .data_rvalid_o(rvld[2]), .data_rdata_o(rdata[2]),
        .gnt_stall_i(stall[2]), .outstanding_o(out_c));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req[k]   = r;
        we[k]    = w;
        addr[k]  = a;
        be[k]    = b;
        wdata[k] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic exp_g [8];
        logic [1:0] exp_oc [8];
        logic exp_v;
        int acc, rsp;

        tbl[0] = '{1'b1, 32'h0000_0010, 4'b1111, 32'hAABB_CCDD, 32'h0};
        tbl[1] = '{1'b1, 32'h0000_0010, 4'b0101, 32'h1122_3344, 32'h0};
        tbl[2] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hAA22_CC44};
        tbl[3] = '{1'b1, 32'h0000_0013, 4'b0000, 32'hFFFF_FFFF, 32'h0};
        tbl[4] = '{1'b0, 32'h0000_0012, 4'b1111, 32'h0,         32'hAA22_CC44};
        tbl[5] = '{1'b1, 32'h0000_0014, 4'b1111, 32'h0102_0304, 32'h0};
        tbl[6] = '{1'b1, 32'h0000_0414, 4'b1010, 32'hDEAD_BEEF, 32'h0};
        tbl[7] = '{1'b0, 32'h0000_0014, 4'b1111, 32'h0,         32'hDE02_BE04};
        tbl[8] = '{1'b1, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 32'h0};
        tbl[9] = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0,         32'hCAFE_F00D};

        exp_g  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_oc = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
            stall[k] = 1'b0;
        end

        // Reset held two edges with req high
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_gnt", gnt[0], 0);
            chk("rst_rvalid", rvld[0], 0);
            chk("rst_rdata", rdata[0], 0);
            chk("rst_out", out_a, 0);
            chk("rst_gnt_c", gnt[2], 0);
        end
        rst = 1'b0;
        #1;
        chk("rel_gnt", gnt[0], 1);
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("noreq_gnt", gnt[0], 0);
        step();
        chk("idle_rvalid", rvld[0], 0);

        // Table-driven single transactions on the LATENCY=1 instance
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata);
            #1;
            chk($sformatf("v%0d_gnt", i), gnt[0], 1);
            step();
            drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            chk($sformatf("v%0d_rvalid", i), rvld[0], 1);
            chk($sformatf("v%0d_rdata", i), rdata[0], tbl[i].exp);
            chk($sformatf("v%0d_out", i), out_a, 1);
            step();
            chk($sformatf("v%0d_rvalid_off", i), rvld[0], 0);
            chk($sformatf("v%0d_rdata_off", i), rdata[0], 0);
            chk($sformatf("v%0d_out_off", i), out_a, 0);
        end

        // Stall holds off a pending write for three cycles
        stall[0] = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h55AA_55AA);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_gnt", gnt[0], 0);
            step();
            chk("stall_rvalid", rvld[0], 0);
            chk("stall_out", out_a, 0);
        end
        stall[0] = 1'b0;
        #1;
        chk("unstall_gnt", gnt[0], 1);
        step();
        drive(0, 1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
        chk("unstall_rvalid", rvld[0], 1);
        chk("unstall_rdata", rdata[0], 0);
        #1;
        chk("unstall_rd_gnt", gnt[0], 1);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("unstall_rd_rvalid", rvld[0], 1);
        chk("unstall_rd_rdata", rdata[0], 32'h55AA_55AA);
        step();

        // Preload words 0..3 of the deep instance back-to-back
        for (int c = 0; c < 4; c++) begin
            drive(1, 1'b1, 1'b1, 32'(c * 4), 4'hF, 32'hB000_0000 + 32'(c));
            #1;
            chk("b_wr_gnt", gnt[1], 1);
            step();
        end
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int c = 0; c < 5; c++) step();
        chk("b_drained", out_b, 0);

        // Four back-to-back reads, LATENCY=3, cap 4
        for (int c = 0; c < 10; c++) begin
            if (c < 4) drive(1, 1'b1, 1'b0, 32'(c * 4), 4'h0, 32'h0);
            else       drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            #1;
            chk($sformatf("b%0d_gnt", c), gnt[1], (c < 4) ? 1 : 0);
            step();
            exp_v = (c >= 2) && (c <= 5);
            acc = (c + 1 < 4) ? c + 1 : 4;
            rsp = (c - 2 < 0) ? 0 : ((c - 2 > 4) ? 4 : c - 2);
            chk($sformatf("b%0d_rvalid", c), rvld[1], exp_v);
            chk($sformatf("b%0d_rdata", c), rdata[1], exp_v ? 32'hB000_0000 + 32'(c - 2) : 32'h0);
            chk($sformatf("b%0d_out", c), out_b, acc - rsp);
        end

        // Outstanding cap on LATENCY=3, cap 2: gnt pattern 1,1,0,0,...
        for (int c = 0; c < 8; c++) begin
            drive(2, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
            #1;
            chk($sformatf("c%0d_gnt", c), gnt[2], exp_g[c]);
            chk($sformatf("c%0d_out", c), out_c, exp_oc[c]);
            chk($sformatf("c%0d_cap", c), (out_c > 2) ? 1 : 0, 0);
            step();
        end
        drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int c = 0; c < 6; c++) step();
        chk("c_drained", out_c, 0);

        // Reset one cycle after the second of two in-flight reads
        drive(2, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        step();
        step();
        drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("mid_pre_out", out_c, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", rvld[2], 0);
        chk("mid_rst_out", out_c, 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("mid_post_rvalid", rvld[2], 0);
            chk("mid_post_rdata", rdata[2], 0);
            chk("mid_post_out", out_c, 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
